// File: rtl/scoreboard_pkg.sv
// Shared constants and helpers for the register write scoreboard.
// The WB-bypass feature is selected with SCOREBOARD_WB_BYPASS_EN.
package scoreboard_pkg;

  localparam int DEF_CNT_W     = 2;
  localparam int NUM_ARCH_REGS = 32;
  localparam int MAX_CNT       = (2 ** DEF_CNT_W) - 1;
  localparam logic [4:0] REG_X0 = 5'd0;

  // Bits needed to hold the sum of all tracked counters at their maximum.
  function automatic int inflight_width(input int num_regs, input int cnt_w);
    return $clog2((num_regs - 1) * ((2 ** cnt_w) - 1) + 1);
  endfunction

endpackage

// File: rtl/sb_counter.sv
// One per-register in-flight write counter with saturation and error detection.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             up,
  output logic             down,
  output logic             err
);

  localparam logic [CNT_W-1:0] MAX_V  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ZERO_V = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_V  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_r;

  assign count = count_r;

  // Classify this cycle's request as a legal step, an error, or no change.
  always_comb begin
    up   = 1'b0;
    down = 1'b0;
    err  = 1'b0;
    if (inc && !dec) begin
      if (count_r == MAX_V) begin
        err = 1'b1;
      end else begin
        up = 1'b1;
      end
    end else if (dec && !inc) begin
      if (count_r == ZERO_V) begin
        err = 1'b1;
      end else begin
        down = 1'b1;
      end
    end else begin
      up = 1'b0;
    end
  end

  // Counter state; saturates at both ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= ZERO_V;
    end else if (up) begin
      count_r <= count_r + ONE_V;
    end else if (down) begin
      count_r <= count_r - ONE_V;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register write scoreboard: tracks in-flight writes from ID issue to WB retire and raises stall.
// Optional macro SCOREBOARD_WB_BYPASS_EN lets a same-cycle WB retire clear a source hazard.
module reg_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int NUM_REGS = NUM_ARCH_REGS
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         id_valid,
  input  logic [4:0]                                   id_rs1,
  input  logic [4:0]                                   id_rs2,
  input  logic                                         id_use_rs1,
  input  logic                                         id_use_rs2,
  input  logic [4:0]                                   id_rd,
  input  logic                                         id_writes_rd,
  input  logic                                         id_issue,
  input  logic                                         wb_retire,
  input  logic [4:0]                                   wb_rd,
  output logic                                         stall,
  output logic [NUM_REGS-1:0]                          busy_vec,
  output logic [inflight_width(NUM_REGS, CNT_W)-1:0]   inflight_total,
  output logic                                         overflow_err
);

  localparam int TOT_W = inflight_width(NUM_REGS, CNT_W);
  localparam logic [CNT_W-1:0] MAX_V  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ZERO_V = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_V  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TOT_W-1:0] TOT_ONE = {{(TOT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]    cnt_s [NUM_REGS];
  logic [NUM_REGS-1:0] dec_vec_s;
  logic [NUM_REGS-1:0] up_s;
  logic [NUM_REGS-1:0] down_s;
  logic [NUM_REGS-1:0] err_s;
  logic                inc_en_s;
  logic                hz1_s;
  logic                hz2_s;
  logic                full_rd_s;
  logic [TOT_W-1:0]    total_r;
  logic                ovf_r;

  assign inc_en_s = id_issue && id_writes_rd;

  // x0 is never tracked: its slot is a constant zero.
  assign cnt_s[0]     = ZERO_V;
  assign dec_vec_s[0] = 1'b0;
  assign up_s[0]      = 1'b0;
  assign down_s[0]    = 1'b0;
  assign err_s[0]     = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    localparam logic [4:0] IDX = 5'(i);
    assign dec_vec_s[i] = wb_retire && (wb_rd == IDX);
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc_en_s && (id_rd == IDX)),
      .dec   (dec_vec_s[i]),
      .count (cnt_s[i]),
      .up    (up_s[i]),
      .down  (down_s[i]),
      .err   (err_s[i])
    );
    assign busy_vec[i] = (cnt_s[i] != ZERO_V);
  end
  assign busy_vec[0] = 1'b0;

  function automatic logic src_hazard(input logic use_rs, input logic [4:0] rs,
                                      input logic [CNT_W-1:0] cnt, input logic dec);
    logic hz;
    if (use_rs && (rs != REG_X0) && (cnt != ZERO_V)) begin
`ifdef SCOREBOARD_WB_BYPASS_EN
      hz = !((cnt == ONE_V) && dec);
`else
      hz = 1'b1;
`endif
    end else begin
      hz = 1'b0;
    end
    return hz;
  endfunction

  // Zero-latency stall from current counters and this cycle's ID/WB inputs.
  always_comb begin
    hz1_s     = src_hazard(id_use_rs1, id_rs1, cnt_s[id_rs1], dec_vec_s[id_rs1]);
    hz2_s     = src_hazard(id_use_rs2, id_rs2, cnt_s[id_rs2], dec_vec_s[id_rs2]);
    full_rd_s = 1'b0;
    if (id_writes_rd && (id_rd != REG_X0) && (cnt_s[id_rd] == MAX_V)) begin
      full_rd_s = !dec_vec_s[id_rd];
    end else begin
      full_rd_s = 1'b0;
    end
    stall = id_valid && (hz1_s || hz2_s || full_rd_s);
  end

  // Running total of legal updates plus the sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      total_r <= {TOT_W{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      case ({|up_s, |down_s})
        2'b10:   total_r <= total_r + TOT_ONE;
        2'b01:   total_r <= total_r - TOT_ONE;
        default: total_r <= total_r;
      endcase
      ovf_r <= ovf_r || (|err_s);
    end
  end

  assign inflight_total = total_r;
  assign overflow_err   = ovf_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard; honours SCOREBOARD_WB_BYPASS_EN.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_writes_rd;
  logic        id_issue;
  logic        wb_retire;
  logic [4:0]  wb_rd;
  logic        stall;
  logic [31:0] busy_vec;
  logic [6:0]  inflight_total;
  logic        overflow_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_writes_rd(id_writes_rd), .id_issue(id_issue), .wb_retire(wb_retire),
    .wb_rd(wb_rd), .stall(stall), .busy_vec(busy_vec),
    .inflight_total(inflight_total), .overflow_err(overflow_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_rd = 5'd0; id_writes_rd = 1'b0; id_issue = 1'b0; wb_retire = 1'b0; wb_rd = 5'd0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Reset state with a reader of x5
    id_valid = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1; #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busy", busy_vec, 32'd0);
    chk("rst_total", 32'(inflight_total), 32'd0);
    chk("rst_ovf", 32'(overflow_err), 32'd0);

    // Issue a write to x5
    idle(); id_valid = 1'b1; id_writes_rd = 1'b1; id_rd = 5'd5; id_issue = 1'b1;
    tick();
    idle();
    chk("x5_busy", busy_vec, 32'h0000_0020);
    chk("x5_total", 32'(inflight_total), 32'd1);

    // Readers of x5 on either port
    id_valid = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1; #1;
    chk("x5_rs1_stall", 32'(stall), 32'd1);
    id_use_rs1 = 1'b0; id_rs2 = 5'd5; id_use_rs2 = 1'b1; #1;
    chk("x5_rs2_stall", 32'(stall), 32'd1);
    id_use_rs2 = 1'b0; #1;
    chk("x5_nouse_stall", 32'(stall), 32'd0);
    id_valid = 1'b0; id_use_rs1 = 1'b1; #1;
    chk("x5_invalid_stall", 32'(stall), 32'd0);

    // Retire x5 while ID reads it
    id_valid = 1'b1; wb_retire = 1'b1; wb_rd = 5'd5; #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
    chk("x5_retire_stall", 32'(stall), 32'd0);
`else
    chk("x5_retire_stall", 32'(stall), 32'd1);
`endif
    tick();
    wb_retire = 1'b0; #1;
    chk("x5_after_stall", 32'(stall), 32'd0);
    chk("x5_after_busy", busy_vec, 32'd0);
    chk("x5_after_total", 32'(inflight_total), 32'd0);

    // x0 is never tracked
    idle(); id_valid = 1'b1; id_writes_rd = 1'b1; id_rd = 5'd0; id_issue = 1'b1;
    wb_retire = 1'b1; wb_rd = 5'd0;
    tick();
    idle(); id_valid = 1'b1; id_rs1 = 5'd0; id_use_rs1 = 1'b1; #1;
    chk("x0_stall", 32'(stall), 32'd0);
    chk("x0_busy", busy_vec, 32'd0);
    chk("x0_total", 32'(inflight_total), 32'd0);
    chk("x0_ovf", 32'(overflow_err), 32'd0);

    // Fill x7 to its maximum of 3
    idle(); id_valid = 1'b1; id_writes_rd = 1'b1; id_rd = 5'd7; id_issue = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    id_issue = 1'b0; #1;
    chk("x7_total", 32'(inflight_total), 32'd3);
    chk("x7_busy", busy_vec, 32'h0000_0080);
    chk("x7_full_stall", 32'(stall), 32'd1);
    wb_retire = 1'b1; wb_rd = 5'd7; #1;
    chk("x7_relief_stall", 32'(stall), 32'd0);
    id_issue = 1'b1;
    tick();
    chk("x7_swap_total", 32'(inflight_total), 32'd3);
    chk("x7_swap_ovf", 32'(overflow_err), 32'd0);
    idle(); wb_retire = 1'b1; wb_rd = 5'd7;
    for (int k = 0; k < 3; k++) tick();
    idle(); #1;
    chk("x7_drain_total", 32'(inflight_total), 32'd0);

    // Same-register issue and retire, then different registers
    id_valid = 1'b1; id_writes_rd = 1'b1; id_rd = 5'd9; id_issue = 1'b1;
    tick();
    wb_retire = 1'b1; wb_rd = 5'd9;
    tick();
    chk("x9_same_total", 32'(inflight_total), 32'd1);
    chk("x9_same_busy", busy_vec, 32'h0000_0200);
    id_rd = 5'd10;
    tick();
    chk("x9x10_total", 32'(inflight_total), 32'd1);
    chk("x9x10_busy", busy_vec, 32'h0000_0400);
    idle(); wb_retire = 1'b1; wb_rd = 5'd10;
    tick();
    chk("x10_drain_total", 32'(inflight_total), 32'd0);
    chk("x10_drain_ovf", 32'(overflow_err), 32'd0);

    // Retire of an idle register sets the sticky error
    wb_rd = 5'd12;
    tick();
    idle();
    chk("x12_ovf", 32'(overflow_err), 32'd1);
    chk("x12_total", 32'(inflight_total), 32'd0);
    tick(); tick();
    chk("x12_ovf_sticky", 32'(overflow_err), 32'd1);

    // x3 and x4 at 2 each, then reset alongside an issue to x3
    id_valid = 1'b1; id_writes_rd = 1'b1; id_issue = 1'b1; id_rd = 5'd3;
    tick(); tick();
    id_rd = 5'd4;
    tick(); tick();
    chk("x34_total", 32'(inflight_total), 32'd4);
    chk("x34_busy", busy_vec, 32'h0000_0018);
    id_rd = 5'd3; reset = 1'b1;
    tick();
    reset = 1'b0; idle(); id_valid = 1'b1; id_rs1 = 5'd3; id_use_rs1 = 1'b1; #1;
    chk("rst2_busy", busy_vec, 32'd0);
    chk("rst2_total", 32'(inflight_total), 32'd0);
    chk("rst2_ovf", 32'(overflow_err), 32'd0);
    chk("rst2_stall", 32'(stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
